// File: rtl/lz77_encoder_param.sv
// LZ77 encoder: loads a fixed-length string into a buffer.
// Then emits one (offset, match_len, char_nxt) codeword per
// SEARCH_LEN+1 cycles until the last string position is emitted.
module lz77_encoder_param #(
   parameter int               WCHAR      = 8,
   parameter int               IN_LEN     = 2049,
   parameter int               SEARCH_LEN = 9,
   parameter int               LOOK_LEN   = 8,
   parameter int               W_OFF      = 4,
   parameter int               W_LEN      = 3,
   parameter int               W_IDX      = 12,
   parameter logic [WCHAR-1:0] END_SGN    = 8'h24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WCHAR-1:0] chardata,
   output logic             valid,
   output logic             encode,
   output logic             finish,
   output logic [W_OFF-1:0] offset,
   output logic [W_LEN-1:0] match_len,
   output logic [WCHAR-1:0] char_nxt
);

   localparam int               AW      = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
   localparam int               CAP_MAX = LOOK_LEN - 1;
   localparam logic [W_IDX-1:0] LAST    = W_IDX'(IN_LEN - 1);
   localparam logic [W_IDX-1:0] CAP_LIM = W_IDX'(CAP_MAX);
   localparam logic [W_OFF-1:0] K_LAST  = W_OFF'(SEARCH_LEN - 1);

   typedef enum logic [1:0] {S_LOAD, S_SEARCH, S_EMIT, S_DONE} state_t;

   state_t           state_q;
   logic [W_IDX-1:0] ld_cnt_q, pos_q;
   logic [W_OFF-1:0] k_q, best_off_q, offset_q;
   logic [W_LEN-1:0] best_len_q, match_len_q;
   logic [WCHAR-1:0] char_nxt_q;
   logic             valid_q, finish_q;
   logic [WCHAR-1:0] buf_q [IN_LEN];

   // End of string is positional; the terminator value is not decoded.
   logic unused_term;
   assign unused_term = ^END_SGN;

   logic [W_IDX-1:0] remain, cap, s_idx, emit_idx;
   logic             cand_ok, run;
   logic [W_LEN-1:0] cand_len_d;
   logic [WCHAR-1:0] emit_char;

   // Candidate match length for offset k_q; cap keeps every read inside the string.
   always_comb begin
      remain     = LAST - pos_q;
      cap        = (remain < CAP_LIM) ? remain : CAP_LIM;
      s_idx      = pos_q - W_IDX'(1) - W_IDX'(k_q);
      cand_ok    = pos_q > W_IDX'(k_q);
      cand_len_d = '0;
      run        = cand_ok;
      for (int j = 0; j < CAP_MAX; j++) begin
         if (run && (W_IDX'(j) < cap)) begin
            if (buf_q[AW'(s_idx + W_IDX'(j))] == buf_q[AW'(pos_q + W_IDX'(j))])
               cand_len_d = cand_len_d + W_LEN'(1);
            else
               run = 1'b0;
         end else begin
            run = 1'b0;
         end
      end
      emit_idx  = pos_q + W_IDX'(best_len_q);
      emit_char = buf_q[AW'(emit_idx)];
   end

   // String buffer, written once per LOAD cycle.
   always_ff @(posedge clk) begin
      if (!reset && state_q == S_LOAD)
         buf_q[AW'(ld_cnt_q)] <= chardata;
   end

   // Control FSM with registered codeword outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_LOAD;
         ld_cnt_q    <= '0;
         pos_q       <= '0;
         k_q         <= '0;
         best_len_q  <= '0;
         best_off_q  <= '0;
         valid_q     <= 1'b0;
         finish_q    <= 1'b0;
         offset_q    <= '0;
         match_len_q <= '0;
         char_nxt_q  <= '0;
      end else begin
         case (state_q)
            S_LOAD: begin
               ld_cnt_q <= ld_cnt_q + W_IDX'(1);
               if (ld_cnt_q == LAST) begin
                  state_q    <= S_SEARCH;
                  k_q        <= '0;
                  best_len_q <= '0;
                  best_off_q <= '0;
               end
            end
            S_SEARCH: begin
               valid_q <= 1'b0;
               // Strict compare: ties keep the smaller offset.
               if (cand_len_d > best_len_q) begin
                  best_len_q <= cand_len_d;
                  best_off_q <= k_q;
               end
               if (k_q == K_LAST) state_q <= S_EMIT;
               else               k_q     <= k_q + W_OFF'(1);
            end
            S_EMIT: begin
               valid_q     <= 1'b1;
               offset_q    <= best_off_q;
               match_len_q <= best_len_q;
               char_nxt_q  <= emit_char;
               pos_q       <= emit_idx + W_IDX'(1);
               k_q         <= '0;
               best_len_q  <= '0;
               best_off_q  <= '0;
               state_q     <= (emit_idx == LAST) ? S_DONE : S_SEARCH;
            end
            default: begin
               valid_q  <= 1'b0;
               finish_q <= 1'b1;
            end
         endcase
      end
   end

   assign valid     = valid_q;
   assign encode    = 1'b1;
   assign finish    = finish_q;
   assign offset    = offset_q;
   assign match_len = match_len_q;
   assign char_nxt  = char_nxt_q;

endmodule

// File: tb/tb_lz77_encoder_param.sv
// Bench for lz77_encoder_param: directed strings from the test plan plus
// random strings checked against a plain LZ77 reference model.
module tb_lz77_encoder_param;

   localparam int NI = 6;
   localparam int LENS [NI] = '{8, 7, 6, 13, 5, 40};
   localparam int SL = 9;
   localparam int LL = 8;

   typedef byte bq_t [$];
   typedef struct {int off; int len; int ch;} cw_t;
   typedef cw_t cwq_t [$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst  [NI];
   logic [7:0] cd   [NI];
   logic       vld  [NI];
   logic       enc  [NI];
   logic       fin  [NI];
   logic [3:0] off  [NI];
   logic [2:0] mlen [NI];
   logic [7:0] cn   [NI];

   int ncmp  = 0;
   int nfail = 0;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      lz77_encoder_param #(.IN_LEN(LENS[g])) u_dut (
         .clk(clk), .reset(rst[g]), .chardata(cd[g]), .valid(vld[g]),
         .encode(enc[g]), .finish(fin[g]), .offset(off[g]),
         .match_len(mlen[g]), .char_nxt(cn[g]));
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic cw_t cw(int o, int l, byte c);
      cw_t r;
      r.off = o; r.len = l; r.ch = c;
      return r;
   endfunction

   function automatic bq_t s2q(string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   // Reference LZ77: greedy longest match over the last SL positions,
   // smallest distance wins ties, match may run into the look-ahead.
   function automatic cwq_t model(bq_t str);
      cwq_t q;
      int L, pos, best, bo, cap, l, st;
      bit done;
      L = str.size(); pos = 0; done = 0;
      while (!done) begin
         best = 0; bo = 0;
         cap = (L - 1 - pos < LL - 1) ? (L - 1 - pos) : (LL - 1);
         for (int k = 0; k < SL; k++) begin
            st = pos - 1 - k;
            if (st >= 0) begin
               l = 0;
               while (l < cap && str[st + l] == str[pos + l]) l++;
               if (l > best) begin best = l; bo = k; end
            end
         end
         q.push_back(cw(bo, best, str[pos + best]));
         if (pos + best == L - 1) done = 1;
         else pos = pos + best + 1;
      end
      return q;
   endfunction

   // One reset cycle (outputs checked cleared), then stream the string in.
   task automatic load(int id, bq_t str, string tag);
      rst[id] = 1'b1;
      @(posedge clk); #1;
      chk({tag, " rst valid"}, vld[id], 0);
      chk({tag, " rst finish"}, fin[id], 0);
      chk({tag, " rst offset"}, off[id], 0);
      chk({tag, " rst len"}, mlen[id], 0);
      chk({tag, " rst char"}, cn[id], 0);
      chk({tag, " rst encode"}, enc[id], 1);
      rst[id] = 1'b0;
      for (int n = 0; n < str.size(); n++) begin
         cd[id] = str[n];
         @(posedge clk); #1;
      end
   endtask

   // Load, then check valid/finish every cycle and codewords on each pulse.
   // abort_cw > 0 stops a few cycles into the search after that codeword.
   task automatic run(int id, bq_t str, cwq_t exp, int abort_cw, string tag);
      int L, first, last, stop, ci;
      logic ev;
      L = str.size();
      first = L + SL;
      last = first + (SL + 1) * (exp.size() - 1);
      stop = (abort_cw > 0) ? first + (SL + 1) * (abort_cw - 1) + 4 : last + 3;
      load(id, str, tag);
      for (int e = L; e <= stop; e++) begin
         @(posedge clk); #1;
         ev = (e >= first) && ((e - first) % (SL + 1) == 0) && (e <= last);
         ci = (e - first) / (SL + 1);
         chk($sformatf("%s valid@%0d", tag, e), vld[id], ev);
         chk($sformatf("%s finish@%0d", tag, e), fin[id], e > last);
         if (ev) begin
            chk($sformatf("%s cw%0d offset", tag, ci), off[id], exp[ci].off);
            chk($sformatf("%s cw%0d len", tag, ci), mlen[id], exp[ci].len);
            chk($sformatf("%s cw%0d char", tag, ci), cn[id], exp[ci].ch);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      cwq_t ex;
      bq_t  s, alpha;
      for (int i = 0; i < NI; i++) begin rst[i] = 1'b1; cd[i] = 8'h00; end
      @(posedge clk); #1;

      // Reset held: outputs stay idle.
      for (int c = 0; c < 20; c++) begin
         chk("hold valid", vld[5], 0);
         chk("hold finish", fin[5], 0);
         chk("hold encode", enc[5], 1);
         @(posedge clk); #1;
      end

      ex.delete(); ex.push_back(cw(0, 0, "a")); ex.push_back(cw(0, 6, "$"));
      run(0, s2q("aaaaaaa$"), ex, 0, "overlap");

      ex.delete();
      ex.push_back(cw(0, 0, "a")); ex.push_back(cw(0, 0, "b"));
      ex.push_back(cw(0, 0, "c")); ex.push_back(cw(2, 3, "$"));
      run(1, s2q("abcabc$"), ex, 0, "abcabc");

      ex.delete();
      ex.push_back(cw(0, 0, "a")); ex.push_back(cw(0, 0, "X"));
      ex.push_back(cw(1, 1, "Y")); ex.push_back(cw(1, 1, "$"));
      run(2, s2q("aXaYa$"), ex, 0, "tiebreak");

      ex.delete();
      s = s2q("abcdefghijab$");
      for (int i = 0; i < 13; i++) ex.push_back(cw(0, 0, s[i]));
      run(3, s, ex, 0, "farmatch");

      ex.delete();
      ex.push_back(cw(0, 0, "a")); ex.push_back(cw(0, 0, "b"));
      ex.push_back(cw(1, 2, "$"));
      run(4, s2q("abab$"), ex, 1, "abort");
      run(4, s2q("abab$"), ex, 0, "reload");

      // Random strings; '$' may appear early as an ordinary character.
      alpha = s2q("abc$");
      for (int it = 0; it < 4; it++) begin
         s.delete();
         for (int i = 0; i < LENS[5] - 1; i++)
            s.push_back(alpha[$urandom_range((it == 0) ? 1 : 3, 0)]);
         s.push_back("$");
         run(5, s, model(s), 0, $sformatf("rand%0d", it));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/lz77_encoder_param.md
Name: lz77_encoder_param

Overview:
Parametrised LZ77 encoder. It buffers a fixed-length character string terminated by END_SGN, then emits one (offset, match_len, char_nxt) codeword per encode step until the terminator has been emitted. Window sizes, character width and string length are set by parameters. It produces the codeword stream consumed by the matching LZ77 decoder.

Parameters:
WCHAR, 8, character width in bits
IN_LEN, 2049, characters per string, including the terminator
SEARCH_LEN, 9, search-buffer depth (maximum backward distance)
LOOK_LEN, 8, look-ahead depth; maximum match_len is LOOK_LEN-1
W_OFF, 4, offset width; must satisfy 2^W_OFF >= SEARCH_LEN
W_LEN, 3, match_len width; must satisfy 2^W_LEN >= LOOK_LEN
W_IDX, 12, index width; must satisfy 2^W_IDX > IN_LEN
END_SGN, 8'h24, terminator character ('$')

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
chardata  input  WCHAR  input character, sampled every LOAD cycle
valid  output  1  one-cycle pulse marking a valid codeword
encode  output  1  tied to 1 (encoder mode)
finish  output  1  high after the last codeword, until reset
offset  output  W_OFF  match start = pos-1-offset
match_len  output  W_LEN  number of matched characters
char_nxt  output  WCHAR  character following the match

Behaviour:
- Reset, synchronous and active-high; one clock, clk. On reset: valid=0, finish=0, offset=0, match_len=0, char_nxt=0, state=LOAD, load count=0, pos=0. Reset overrides every state, including mid-SEARCH.
- All outputs are registered.
- LOAD
  - Edge n after reset release (n=0..IN_LEN-1) stores chardata into buf[n].
  - After edge IN_LEN-1: go to SEARCH with k=0, best_len=0, best_off=0.
- SEARCH: one candidate offset per cycle, k=0..SEARCH_LEN-1.
  - Candidate start s=pos-1-k. If s<0, the candidate length is 0.
  - Candidate length = count of leading j where buf[s+j]==buf[pos+j], for j<cap.
  - cap = min(LOOK_LEN-1, IN_LEN-1-pos), so char_nxt always lies inside the string.
  - Overlap into the look-ahead is allowed (s+j may be >= pos).
  - Update best only when candidate length > best_len (strict). Ties therefore keep the smallest offset.
  - After k=SEARCH_LEN-1: go to EMIT.
- EMIT (1 cycle)
  - On entry edge, register: valid=1, offset=best_off (0 if best_len=0), match_len=best_len, char_nxt=buf[pos+best_len].
  - pos advances by best_len+1.
  - If the emitted char_nxt index equals IN_LEN-1: go to DONE. Otherwise go to SEARCH with best cleared.
- Timing: valid is high for exactly 1 cycle per codeword.
  - Codeword period: SEARCH_LEN+1 cycles.
  - First valid: the cycle after edge IN_LEN+SEARCH_LEN.
- DONE
  - Edge after the last EMIT: valid=0, finish=1.
  - offset, match_len and char_nxt hold their last values.
  - Stays in DONE until reset.
- END_SGN is not detected by content; the end of string is position IN_LEN-1. END_SGN appearing earlier in the string is an ordinary character.
- Arithmetic:
  - Indices are unsigned W_IDX bits.
  - The s<0 test uses pos<=k, not a wrapped subtraction.
  - Out-of-range buf reads never affect the result, because cap bounds j.

Test Plan:
- IN_LEN=8, "aaaaaaa$" -> (0,0,'a'), then (0,6,'$') (overlapping match); finish high the cycle after the second valid.
- IN_LEN=7, "abcabc$" -> (0,0,'a'), (0,0,'b'), (0,0,'c'), (2,3,'$'); first valid after edge 7+9=16; valid pulses spaced 10 cycles apart.
- IN_LEN=6, "aXaYa$" -> (0,0,'a'), (0,0,'X'), (1,1,'Y'), (1,1,'$'). The last step checks the tie-break: offsets 1 and 3 both give length 1, and offset 1 is chosen.
- IN_LEN=13, "abcdefghijab$" -> 10 literal codewords ('a'..'j', each (0,0,c)); then (0,0,'a') and (0,0,'b') because distance 10 exceeds SEARCH_LEN=9; then (0,0,'$'). Exactly 13 valid pulses.
- Assert reset for 1 cycle mid-SEARCH of the second codeword -> next cycle all outputs are 0 and state is LOAD. Reloading "abab$" (IN_LEN=5) yields (0,0,'a'), (0,0,'b'), (1,2,'$') and finish.
- Hold reset throughout -> valid=0, finish=0 and encode=1 on every cycle.
